// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//
// Purpose:
//   Drives the select lines of an external 4:1 mux, waits SETTLE_CYCLES clock
//   cycles per channel and captures the mux output into a 4-bit word. Bit n of
//   the word holds the sample taken while select n was applied. The finished
//   word is held with word_valid until the consumer acknowledges it.
//
// Parameters:
//   SETTLE_CYCLES  cycles each select value is held before sampling (1..15)
//
// Ports:
//   clk         in   sole clock, rising edge
//   reset       in   asynchronous, active-high reset
//   start       in   request to begin one 4-channel scan
//   busy        out  high while a scan runs or a result is held
//   S0          out  mux select LSB (registered)
//   S1          out  mux select MSB (registered)
//   mux_out     in   output of the downstream 4:1 mux
//   word        out  captured word, bit n = sample taken with select n
//   word_valid  out  word is complete and stable
//   word_ack    in   consumer accepts word (only honoured while holding)
//   parity      out  XOR of word[3:0], registered (only with the macro below)
//
// Configuration:
//   MUX_SCAN_PARITY_EN  when defined, adds the registered parity output.

module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       S0,
  output logic       S1,
  input  logic       mux_out,
  output logic [3:0] word,
  output logic       word_valid,
  input  logic       word_ack
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       parity
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Settle counter value on which the current channel is sampled.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] sel;
  logic [1:0] sel_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic [3:0] word_q;
  logic [3:0] word_nxt;
  logic       valid_q;
  logic       valid_nxt;
`ifdef MUX_SCAN_PARITY_EN
  logic       parity_q;
  logic       parity_nxt;
`endif

  // State register: FSM state plus the select, settle counter and captured
  // word. Everything clears asynchronously so a reset mid-scan can never leave
  // a partial word flagged valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= 2'd0;
      cnt     <= 4'd0;
      word_q  <= 4'd0;
      valid_q <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      cnt     <= cnt_nxt;
      word_q  <= word_nxt;
      valid_q <= valid_nxt;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= parity_nxt;
`endif
    end
  end

  // Next-state logic. A new scan always restarts from select 0 with a cleared
  // word; leaving HOLD returns the select to 0 so the mux lines rest at 00
  // while idle. start is only honoured in IDLE or together with an ack in
  // HOLD, which lets back-to-back scans run without an idle cycle.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    word_nxt  = word_q;
    valid_nxt = valid_q;
`ifdef MUX_SCAN_PARITY_EN
    parity_nxt = parity_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
          sel_nxt   = 2'd0;
          cnt_nxt   = 4'd0;
          word_nxt  = 4'd0;
          valid_nxt = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
          parity_nxt = 1'b0;
`endif
        end
      end
      SETTLE: begin
        if (cnt == CNT_LAST) begin
          word_nxt[sel] = mux_out;
          cnt_nxt       = 4'd0;
          if (sel == 2'd3) begin
            state_nxt = HOLD;
            valid_nxt = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
            // The last bit is being captured on this edge, so fold it in
            // directly rather than reading the not-yet-updated register.
            parity_nxt = ^{mux_out, word_q[2:0]};
`endif
          end else begin
            sel_nxt = sel + 2'd1;
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      HOLD: begin
        if (word_ack) begin
          valid_nxt = 1'b0;
          sel_nxt   = 2'd0;
          cnt_nxt   = 4'd0;
          if (start) begin
            state_nxt = SETTLE;
            word_nxt  = 4'd0;
`ifdef MUX_SCAN_PARITY_EN
            parity_nxt = 1'b0;
`endif
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = 2'd0;
        cnt_nxt   = 4'd0;
        word_nxt  = 4'd0;
        valid_nxt = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
        parity_nxt = 1'b0;
`endif
      end
    endcase
  end

  // Outputs come straight from registers, so the mux selects have no
  // combinational path from any input.
  always_comb begin
    busy       = (state != IDLE);
    S0         = sel[0];
    S1         = sel[1];
    word       = word_q;
    word_valid = valid_q;
`ifdef MUX_SCAN_PARITY_EN
    parity     = parity_q;
`endif
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer
//
// Purpose:
//   Directed bench for mux_scan_sequencer. Two instances share one clock: one
//   with SETTLE_CYCLES=2 and one with SETTLE_CYCLES=1. Each instance sees a
//   small 4:1 mux model built from a 4-bit input pattern. Expected values are
//   hand-computed constants.
//
// Configuration:
//   MUX_SCAN_PARITY_EN  when defined, the parity output is connected and checked.

module tb_mux_scan_sequencer;

  logic       clk;
  logic       reset;

  logic       start_a;
  logic       ack_a;
  logic [3:0] in_a;
  logic       busy_a;
  logic       s0_a;
  logic       s1_a;
  logic       mux_a;
  logic [3:0] word_a;
  logic       valid_a;
  logic       parity_a;

  logic       start_b;
  logic       ack_b;
  logic [3:0] in_b;
  logic       busy_b;
  logic       s0_b;
  logic       s1_b;
  logic       mux_b;
  logic [3:0] word_b;
  logic       valid_b;
  logic       parity_b;

  int checks;
  int errors;

  // 4:1 mux models feeding each instance.
  assign mux_a = in_a[{s1_a, s0_a}];
  assign mux_b = in_b[{s1_b, s0_b}];

`ifndef MUX_SCAN_PARITY_EN
  assign parity_a = 1'b0;
  assign parity_b = 1'b0;
`endif

  mux_scan_sequencer #(.SETTLE_CYCLES(2)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .start      (start_a),
    .busy       (busy_a),
    .S0         (s0_a),
    .S1         (s1_a),
    .mux_out    (mux_a),
    .word       (word_a),
    .word_valid (valid_a),
    .word_ack   (ack_a)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .parity     (parity_a)
`endif
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(1)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .start      (start_b),
    .busy       (busy_b),
    .S0         (s0_b),
    .S1         (s1_b),
    .mux_out    (mux_b),
    .word       (word_b),
    .word_valid (valid_b),
    .word_ack   (ack_b)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .parity     (parity_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [1:0] selOf(input int which);
    return (which == 0) ? {s1_a, s0_a} : {s1_b, s0_b};
  endfunction

  function automatic logic validOf(input int which);
    return (which == 0) ? valid_a : valid_b;
  endfunction

  function automatic logic busyOf(input int which);
    return (which == 0) ? busy_a : busy_b;
  endfunction

  function automatic logic [3:0] wordOf(input int which);
    return (which == 0) ? word_a : word_b;
  endfunction

  function automatic logic parityOf(input int which);
    return (which == 0) ? parity_a : parity_b;
  endfunction

  // Present a mux input pattern and pulse start across one rising edge
  // (edge 0 of the scan). Returns on the falling edge after it.
  task automatic applyStimulus(input int which, input logic [3:0] pattern);
    if (which == 0) begin
      in_a    = pattern;
      start_a = 1'b1;
    end else begin
      in_b    = pattern;
      start_b = 1'b1;
    end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Run one full scan, checking the select sequence, the exact edge on which
  // word_valid rises, and the captured word / parity.
  task automatic runScan(input int which, input int sc, input logic [3:0] pattern,
                         input logic exp_parity, input string tag);
    applyStimulus(which, pattern);
    checkOutput({tag, " sel e0"}, 8'(selOf(which)), 8'd0);
    checkOutput({tag, " busy e0"}, 8'(busyOf(which)), 8'd1);
    checkOutput({tag, " word clr e0"}, 8'(wordOf(which)), 8'd0);
    for (int k = 1; k <= 4 * sc; k++) begin
      tick();
      checkOutput($sformatf("%s valid e%0d", tag, k), 8'(validOf(which)),
                  8'(k == 4 * sc));
      if (k < 4 * sc)
        checkOutput($sformatf("%s sel e%0d", tag, k), 8'(selOf(which)),
                    8'(k / sc));
    end
    checkOutput({tag, " word"}, 8'(wordOf(which)), 8'(pattern));
`ifdef MUX_SCAN_PARITY_EN
    checkOutput({tag, " parity"}, 8'(parityOf(which)), 8'(exp_parity));
`else
    if (exp_parity !== parityOf(which) && 1'b0) checkOutput(tag, 8'd0, 8'd0);
`endif
  endtask

  // Acknowledge the held word without a new start and confirm return to IDLE.
  task automatic ackToIdle(input int which, input string tag);
    if (which == 0) ack_a = 1'b1;
    else            ack_b = 1'b1;
    tick();
    ack_a = 1'b0;
    ack_b = 1'b0;
    checkOutput({tag, " ack valid"}, 8'(validOf(which)), 8'd0);
    checkOutput({tag, " ack busy"}, 8'(busyOf(which)), 8'd0);
    checkOutput({tag, " ack sel"}, 8'(selOf(which)), 8'd0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    start_a = 1'b0;
    ack_a   = 1'b0;
    in_a    = 4'd0;
    start_b = 1'b0;
    ack_b   = 1'b0;
    in_b    = 4'd0;

    // Reset state.
    tick();
    tick();
    checkOutput("rst busy", 8'({busy_a, busy_b}), 8'd0);
    checkOutput("rst sel", 8'({s1_a, s0_a, s1_b, s0_b}), 8'd0);
    checkOutput("rst valid", 8'({valid_a, valid_b}), 8'd0);
    checkOutput("rst word", {word_a, word_b}, 8'd0);
`ifdef MUX_SCAN_PARITY_EN
    checkOutput("rst parity", 8'({parity_a, parity_b}), 8'd0);
`endif
    reset = 1'b0;
    tick();
    checkOutput("idle busy", 8'(busy_a), 8'd0);

    // SETTLE_CYCLES=2 scans.
    runScan(0, 2, 4'b0001, 1'b1, "s2 0001");
    ackToIdle(0, "s2 0001");
    runScan(0, 2, 4'b1110, 1'b1, "s2 1110");

    // Held word must survive ten cycles of start pulses without ack.
    for (int i = 0; i < 10; i++) begin
      start_a = (i == 3);
      tick();
      checkOutput($sformatf("hold valid c%0d", i), 8'(valid_a), 8'd1);
      checkOutput($sformatf("hold word c%0d", i), 8'(word_a), 8'b1110);
      checkOutput($sformatf("hold busy c%0d", i), 8'(busy_a), 8'd1);
    end
    start_a = 1'b0;

    // Ack together with start restarts immediately with no idle cycle.
    in_a    = 4'b0101;
    ack_a   = 1'b1;
    start_a = 1'b1;
    tick();
    ack_a   = 1'b0;
    start_a = 1'b0;
    checkOutput("restart valid", 8'(valid_a), 8'd0);
    checkOutput("restart busy", 8'(busy_a), 8'd1);
    checkOutput("restart sel", 8'({s1_a, s0_a}), 8'd0);
    checkOutput("restart word", 8'(word_a), 8'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkOutput($sformatf("restart valid e%0d", k), 8'(valid_a), 8'(k == 8));
    end
    checkOutput("restart word 0101", 8'(word_a), 8'b0101);
`ifdef MUX_SCAN_PARITY_EN
    checkOutput("restart parity", 8'(parity_a), 8'd0);
`endif
    ackToIdle(0, "restart");

    // Reset between edges while sel=2 aborts the scan immediately.
    applyStimulus(0, 4'b1111);
    for (int k = 1; k <= 4; k++) tick();
    checkOutput("pre-abort sel", 8'({s1_a, s0_a}), 8'd2);
    checkOutput("pre-abort word", 8'(word_a), 8'b0011);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort busy", 8'(busy_a), 8'd0);
    checkOutput("abort sel", 8'({s1_a, s0_a}), 8'd0);
    checkOutput("abort valid", 8'(valid_a), 8'd0);
    checkOutput("abort word", 8'(word_a), 8'd0);
`ifdef MUX_SCAN_PARITY_EN
    checkOutput("abort parity", 8'(parity_a), 8'd0);
`endif
    @(negedge clk);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("post-abort valid c%0d", i), 8'(valid_a), 8'd0);
      checkOutput($sformatf("post-abort busy c%0d", i), 8'(busy_a), 8'd0);
    end
    runScan(0, 2, 4'b0110, 1'b0, "s2 0110");
    ackToIdle(0, "s2 0110");

    // SETTLE_CYCLES=1 scan; word_ack held high throughout must be ignored
    // until the word is actually held, then release it on the next edge.
    ack_b = 1'b1;
    runScan(1, 1, 4'b1010, 1'b0, "s1 1010");
    tick();
    ack_b = 1'b0;
    checkOutput("s1 early-ack valid", 8'(valid_b), 8'd0);
    checkOutput("s1 early-ack busy", 8'(busy_b), 8'd0);
    checkOutput("s1 word kept", 8'(word_b), 8'b1010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 1; clock cycles each select value is held before the mux output is sampled, legal range 1..15.
REQ-002 Port: clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 Port: reset  in  1  reset, asynchronous and active-high.
REQ-004 Port: start  in  1  request to begin one 4-channel scan.
REQ-005 Port: busy  out  1  high while a scan runs or a result is held.
REQ-006 Port: S0  out  1  mux select LSB, drives the 4:1 mux S0 input.
REQ-007 Port: S1  out  1  mux select MSB, drives the 4:1 mux S1 input.
REQ-008 Port: mux_out  in  1  output of the downstream 4:1 mux.
REQ-009 Port: word  out  4  captured word; bit n holds the sample taken with select n.
REQ-010 Port: word_valid  out  1  word is complete and stable.
REQ-011 Port: word_ack  in  1  consumer accepts word.
REQ-012 Port: parity  out  1  XOR of word[3:0]; present only with MUX_SCAN_PARITY_EN.

Function
REQ-013 FSM states: IDLE, SETTLE, HOLD; registered state, sel[1:0] and settle counter cnt[3:0].
REQ-014 Select encoding: {S1,S0} = sel; sel 0 -> in0, 1 -> in1 (S0=1,S1=0), 2 -> in2 (S0=0,S1=1), 3 -> in3.
REQ-015 S0 and S1 are driven from registers, no combinational path from any input.
REQ-016 IDLE with start=1: next state SETTLE, sel=0, cnt=0, word=4'b0000.
REQ-017 IDLE with start=0: remain IDLE; S0=S1=0.
REQ-018 SETTLE: cnt increments each cycle; on the edge where cnt==SETTLE_CYCLES-1, word[sel] <= mux_out and cnt <= 0.
REQ-019 On that sampling edge: if sel<3, sel increments and the state stays SETTLE; if sel==3, next state is HOLD and word_valid is set.
REQ-020 Latency: word_valid rises exactly 4*SETTLE_CYCLES clock edges after the edge that accepted start.
REQ-021 HOLD: word, word_valid and parity stay stable until word_ack=1 is sampled.
REQ-022 HOLD with word_ack=1 and start=0: next state IDLE; word_valid clears on the same edge.
REQ-023 HOLD with word_ack=1 and start=1: next state SETTLE, sel=0, word cleared, word_valid cleared, no idle cycle.
REQ-024 start is ignored in SETTLE, and in HOLD without word_ack.
REQ-025 word_ack is ignored outside HOLD.
REQ-026 busy = (state != IDLE).

Reset
REQ-027 reset=1 immediately, without a clock edge, forces state=IDLE, sel=0, cnt=0, word=0, word_valid=0, busy=0, S0=S1=0, parity=0.
REQ-028 reset asserted mid-scan aborts the scan; no partial word is ever flagged valid.
REQ-029 The first edge after reset deasserts obeys REQ-016/017.

Configuration
REQ-030 Macro MUX_SCAN_PARITY_EN defined: parity port exists, registered, updated on the edge word_valid sets, cleared with word.
REQ-031 Macro MUX_SCAN_PARITY_EN undefined: parity port and its logic are absent; all other behaviour is identical.

Verification
REQ-032 Reset asserted between edges -> all outputs 0 before the next clk edge.
REQ-033 SETTLE_CYCLES=2, inputs {in3,in2,in1,in0}=0001, start pulse -> {S1,S0} steps 00,01,10,11 for 2 cycles each; word_valid high at edge 8; word=0001; parity=1.
REQ-034 SETTLE_CYCLES=2, inputs=1110, start pulse -> word=1110 and parity=1 at edge 8.
REQ-035 In HOLD, word_ack=0 for 10 cycles with start pulsed -> word_valid and word unchanged, busy=1; then word_ack=1 with start=1 -> next edge word_valid=0, state SETTLE, sel=0.
REQ-036 reset pulsed while sel=2 -> outputs 0 immediately, word_valid never rises; following start with inputs=0110 -> word=0110.
REQ-037 SETTLE_CYCLES=1, inputs=1010, start pulse -> word_valid at edge 4; word=1010; parity=0.
